// File: rtl/ase_pkg.sv
// Shared types for the CCI-P write-response packer.
// Tracking-table entry layout, request length encoding and mask helper.
package ase_pkg;

    localparam int ASE_TAG_W   = 8;
    localparam int ASE_MDATA_W = 16;

    typedef enum logic [1:0] {
        WR_LEN_1CL = 2'd0,
        WR_LEN_2CL = 2'd1,
        WR_LEN_4CL = 2'd3
    } wrresp_len_e;

    typedef struct packed {
        logic                   valid;
        logic [ASE_TAG_W-1:0]   tag;
        wrresp_len_e            len;
        logic [1:0]             vc;
        logic [ASE_MDATA_W-1:0] mdata;
        logic [3:0]             mask;
    } wrresp_entry_t;

    function automatic logic [3:0] len_to_mask(input wrresp_len_e len);
        case (len)
            WR_LEN_2CL: len_to_mask = 4'b0011;
            WR_LEN_4CL: len_to_mask = 4'b1111;
            default:    len_to_mask = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/wrresp_track_table.sv
// Tag-indexed table of outstanding multi-CL write requests.
// CAM lookup, lowest-free allocation, mask merge and completion detect.
module wrresp_track_table
    import ase_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = ASE_TAG_W,
    parameter int MDATA_W = ASE_MDATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TAG_W-1:0]   lk_tag_i,
    input  logic               upd_i,
    input  logic [1:0]         len_i,
    input  logic [1:0]         cl_i,
    input  logic [1:0]         vc_i,
    input  logic [MDATA_W-1:0] mdata_i,
    output logic               hit_o,
    output logic               full_o,
    output logic               any_o,
    output logic               dup_o,
    output logic               done_o,
    output logic [1:0]         vc_o,
    output logic [MDATA_W-1:0] mdata_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wrresp_entry_t    ent_q [DEPTH];
    wrresp_entry_t    hit_e;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic             free_ok;
    logic [3:0]       bit_sel;
    logic [3:0]       mask_nx;

    // Tag match, lowest free slot and occupancy scan
    always_comb begin
        hit_o    = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        any_o    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].tag == lk_tag_i) begin
                hit_o   = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!ent_q[i].valid && !free_ok) begin
                free_ok  = 1'b1;
                free_idx = IDX_W'(i);
            end
            any_o = any_o | ent_q[i].valid;
        end
    end

    assign hit_e   = ent_q[hit_idx];
    assign bit_sel = 4'b0001 << cl_i;
    assign mask_nx = hit_e.mask | bit_sel;
    assign dup_o   = hit_o & |(hit_e.mask & bit_sel);
    assign done_o  = hit_o & ~dup_o &
                     (mask_nx == len_to_mask(hit_e.len));
    assign full_o  = ~free_ok;
    assign vc_o    = hit_e.vc;
    assign mdata_o = hit_e.mdata;

    // Allocate on miss, merge mask on hit, free on completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (upd_i) begin
            if (hit_o) begin
                if (done_o) begin
                    ent_q[hit_idx] <= '0;
                end else if (!dup_o) begin
                    ent_q[hit_idx].mask <= mask_nx;
                end
            end else if (free_ok) begin
                ent_q[free_idx] <= '{valid: 1'b1,
                                     tag:   lk_tag_i,
                                     len:   wrresp_len_e'(len_i),
                                     vc:    vc_i,
                                     mdata: mdata_i,
                                     mask:  bit_sel};
            end
        end
    end

endmodule

// File: rtl/wrresp_packer.sv
// Coalesces per-line write responses into one response per request.
// Optional response counters enabled by ASE_WRRESP_STATS_EN.
module wrresp_packer
    import ase_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = ASE_TAG_W,
    parameter int MDATA_W = ASE_MDATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [1:0]         in_vc,
    input  logic [1:0]         in_len,
    input  logic [1:0]         in_cl_num,
    input  logic [MDATA_W-1:0] in_mdata,
    input  logic               in_is_fence,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_vc,
    output logic               out_format,
    output logic [1:0]         out_cl_num,
    output logic [MDATA_W-1:0] out_mdata,
    output logic               out_is_fence,
    output logic [2:0]         err
`ifdef ASE_WRRESP_STATS_EN
    ,
    output logic [31:0]        cnt_single,
    output logic [31:0]        cnt_packed,
    output logic [31:0]        cnt_fence
`endif
);

    logic               tt_hit, tt_full, tt_any;
    logic               tt_dup, tt_done;
    logic [1:0]         tt_vc;
    logic [MDATA_W-1:0] tt_mdata;

    logic               ld_ok, acc, illegal, new_multi;
    logic               c_fence, c_bad, c_one, c_multi;

    logic               emit_d, fmt_d, fence_d;
    logic [1:0]         cl_d, vc_d;
    logic [MDATA_W-1:0] md_d;
    logic [2:0]         err_set;

    logic               out_valid_q, out_format_q, out_is_fence_q;
    logic [1:0]         out_vc_q, out_cl_num_q;
    logic [MDATA_W-1:0] out_mdata_q;
    logic [2:0]         err_q;

    assign illegal   = (in_len == 2'd2) | (in_cl_num > in_len);
    assign new_multi = (in_len != 2'd0) & ~in_is_fence & ~tt_hit;
    assign ld_ok     = ~out_valid_q | out_ready;
    assign in_ready  = rst & ld_ok & ~(new_multi & tt_full);
    assign acc       = in_valid & in_ready;

    assign c_fence = in_is_fence;
    assign c_bad   = ~in_is_fence & illegal;
    assign c_one   = ~in_is_fence & ~illegal & (in_len == 2'd0);
    assign c_multi = ~in_is_fence & ~illegal & (in_len != 2'd0);

    wrresp_track_table #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .MDATA_W (MDATA_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .lk_tag_i (in_tag),
        .upd_i    (acc & c_multi),
        .len_i    (in_len),
        .cl_i     (in_cl_num),
        .vc_i     (in_vc),
        .mdata_i  (in_mdata),
        .hit_o    (tt_hit),
        .full_o   (tt_full),
        .any_o    (tt_any),
        .dup_o    (tt_dup),
        .done_o   (tt_done),
        .vc_o     (tt_vc),
        .mdata_o  (tt_mdata)
    );

    // Classify the accepted line into a response and error flags
    always_comb begin
        emit_d  = 1'b0;
        fmt_d   = 1'b0;
        fence_d = 1'b0;
        cl_d    = 2'd0;
        vc_d    = in_vc;
        md_d    = in_mdata;
        err_set = 3'b000;
        if (acc) begin
            unique case (1'b1)
                c_fence: begin
                    emit_d     = 1'b1;
                    fence_d    = 1'b1;
                    err_set[2] = tt_any;
                end
                c_bad: begin
                    err_set[1] = 1'b1;
                end
                c_one: begin
                    emit_d = 1'b1;
                    cl_d   = in_cl_num;
                end
                c_multi: begin
                    err_set[0] = tt_dup;
                    emit_d     = tt_done;
                    fmt_d      = 1'b1;
                    cl_d       = in_len;
                    vc_d       = tt_vc;
                    md_d       = tt_mdata;
                end
            endcase
        end
    end

    // Single-entry output register, held while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_format_q   <= 1'b0;
            out_is_fence_q <= 1'b0;
            out_vc_q       <= 2'd0;
            out_cl_num_q   <= 2'd0;
            out_mdata_q    <= '0;
        end else if (ld_ok) begin
            out_valid_q <= emit_d;
            if (emit_d) begin
                out_format_q   <= fmt_d;
                out_is_fence_q <= fence_d;
                out_vc_q       <= vc_d;
                out_cl_num_q   <= cl_d;
                out_mdata_q    <= md_d;
            end
        end
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) err_q <= 3'b000;
        else      err_q <= err_q | err_set;
    end

    assign out_valid    = out_valid_q;
    assign out_format   = out_format_q;
    assign out_is_fence = out_is_fence_q;
    assign out_vc       = out_vc_q;
    assign out_cl_num   = out_cl_num_q;
    assign out_mdata    = out_mdata_q;
    assign err          = err_q;

`ifdef ASE_WRRESP_STATS_EN
    logic [31:0] cs_q, cp_q, cf_q;
    logic        ld_any;

    assign ld_any = ld_ok & emit_d;

    // Saturating per-kind response counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_q <= '0;
            cp_q <= '0;
            cf_q <= '0;
        end else if (ld_any) begin
            if (fence_d && cf_q != '1)            cf_q <= cf_q + 32'd1;
            if (!fence_d && fmt_d && cp_q != '1)  cp_q <= cp_q + 32'd1;
            if (!fence_d && !fmt_d && cs_q != '1) cs_q <= cs_q + 32'd1;
        end
    end

    assign cnt_single = cs_q;
    assign cnt_packed = cp_q;
    assign cnt_fence  = cf_q;
`endif

endmodule

// File: tb/tb_wrresp_packer.sv
// Self-checking bench for wrresp_packer.
// Reference model keeps outstanding requests keyed by tag.
module tb_wrresp_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_tag = '0;
    logic [1:0]  in_vc = '0;
    logic [1:0]  in_len = '0;
    logic [1:0]  in_cl_num = '0;
    logic [15:0] in_mdata = '0;
    logic        in_is_fence = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_vc;
    logic        out_format;
    logic [1:0]  out_cl_num;
    logic [15:0] out_mdata;
    logic        out_is_fence;
    logic [2:0]  err;
`ifdef ASE_WRRESP_STATS_EN
    logic [31:0] cnt_single, cnt_packed, cnt_fence;
`endif

    always #5 clk = ~clk;

    wrresp_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .in_vc        (in_vc),
        .in_len       (in_len),
        .in_cl_num    (in_cl_num),
        .in_mdata     (in_mdata),
        .in_is_fence  (in_is_fence),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vc       (out_vc),
        .out_format   (out_format),
        .out_cl_num   (out_cl_num),
        .out_mdata    (out_mdata),
        .out_is_fence (out_is_fence),
        .err          (err)
`ifdef ASE_WRRESP_STATS_EN
        ,
        .cnt_single   (cnt_single),
        .cnt_packed   (cnt_packed),
        .cnt_fence    (cnt_fence)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int       len;
        bit [3:0] mask;
        bit [1:0] vc;
        bit [15:0] md;
    } ment_t;

    ment_t     tbl[int];
    bit        mv;
    bit        mfmt;
    bit        mfence;
    bit [1:0]  mcl;
    bit [1:0]  mvc;
    bit [15:0] mmd;
    bit [2:0]  merr;

    always @(negedge clk) begin
        bit        newm, er, emit, efmt, efence;
        bit [1:0]  ecl, evc;
        bit [15:0] emd;
        int        t;
        ment_t     e;
        if (chk_en) begin
            t    = int'(in_tag);
            newm = in_len != 2'd0 && !in_is_fence && !tbl.exists(t);
            er   = rst && (!mv || out_ready) && !(newm && tbl.num() >= 8);
            chk("m.in_ready", 32'(in_ready), 32'(er));
            chk("m.out_valid", 32'(out_valid), 32'(mv));
            chk("m.err", 32'(err), 32'(merr));
            if (mv) begin
                chk("m.format", 32'(out_format), 32'(mfmt));
                chk("m.cl_num", 32'(out_cl_num), 32'(mcl));
                chk("m.vc", 32'(out_vc), 32'(mvc));
                chk("m.mdata", 32'(out_mdata), 32'(mmd));
                chk("m.fence", 32'(out_is_fence), 32'(mfence));
            end
            if (!rst) begin
                tbl.delete();
                mv = 0; mfmt = 0; mfence = 0;
                mcl = 0; mvc = 0; mmd = 0; merr = 0;
            end else begin
                emit = 0; efmt = 0; efence = 0;
                ecl = 0; evc = in_vc; emd = in_mdata;
                if (in_valid && er) begin
                    if (in_is_fence) begin
                        emit = 1; efence = 1;
                        if (tbl.num() > 0) merr[2] = 1;
                    end else if (in_len == 2 || in_cl_num > in_len) begin
                        merr[1] = 1;
                    end else if (in_len == 0) begin
                        emit = 1; ecl = in_cl_num;
                    end else if (tbl.exists(t)) begin
                        e = tbl[t];
                        if (e.mask[in_cl_num]) begin
                            merr[0] = 1;
                        end else begin
                            e.mask[in_cl_num] = 1;
                            tbl[t] = e;
                            if (e.mask == ((e.len == 3) ? 4'hF : 4'h3)) begin
                                emit = 1; efmt = 1;
                                ecl = 2'(e.len);
                                evc = e.vc; emd = e.md;
                                tbl.delete(t);
                            end
                        end
                    end else begin
                        e.len  = int'(in_len);
                        e.mask = 4'b0000;
                        e.mask[in_cl_num] = 1;
                        e.vc   = in_vc;
                        e.md   = in_mdata;
                        tbl[t] = e;
                    end
                end
                if (!mv || out_ready) begin
                    mv = emit;
                    if (emit) begin
                        mfmt = efmt; mfence = efence;
                        mcl = ecl; mvc = evc; mmd = emd;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] tag, input logic [1:0] len,
                        input logic [1:0] cl, input logic [15:0] md,
                        input logic [1:0] vc, input logic fence,
                        output int waits);
        bit ok;
        in_tag = tag; in_len = len; in_cl_num = cl;
        in_mdata = md; in_vc = vc; in_is_fence = fence;
        in_valid = 1'b1;
        waits = 0;
        ok = 0;
        while (!ok && waits < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        if (!ok) chk("send.timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        in_is_fence = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic fmt,
                           input logic [1:0] cl, input logic [15:0] md,
                           input logic [1:0] vc, input logic fence,
                           input logic [2:0] ev);
        @(negedge clk);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".format"}, 32'(out_format), 32'(fmt));
        chk({nm, ".cl_num"}, 32'(out_cl_num), 32'(cl));
        chk({nm, ".mdata"}, 32'(out_mdata), 32'(md));
        chk({nm, ".vc"}, 32'(out_vc), 32'(vc));
        chk({nm, ".fence"}, 32'(out_is_fence), 32'(fence));
        chk({nm, ".err"}, 32'(err), 32'(ev));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm, input logic [2:0] ev);
        @(negedge clk);
        chk({nm, ".valid"}, 32'(out_valid), 32'd0);
        chk({nm, ".err"}, 32'(err), 32'(ev));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.mdata", 32'(out_mdata), 32'd0);
        chk("rst.fields", {out_vc, out_format, out_cl_num, out_is_fence},
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        send(8'd1, 2'd0, 2'd0, 16'h0010, 2'd1, 1'b0, w);
        chk_out("single", 1'b0, 2'd0, 16'h0010, 2'd1, 1'b0, 3'b000);

        send(8'd5, 2'd3, 2'd2, 16'h00AB, 2'd2, 1'b0, w);
        send(8'd5, 2'd3, 2'd0, 16'h00AB, 2'd2, 1'b0, w);
        send(8'd5, 2'd3, 2'd3, 16'h00AB, 2'd2, 1'b0, w);
        send(8'd5, 2'd3, 2'd1, 16'h00AB, 2'd2, 1'b0, w);
        chk_out("pk4", 1'b1, 2'd3, 16'h00AB, 2'd2, 1'b0, 3'b000);
        send(8'd0, 2'd0, 2'd0, 16'h00F0, 2'd0, 1'b1, w);
        chk_out("pk4.empty", 1'b0, 2'd0, 16'h00F0, 2'd0, 1'b1, 3'b000);

        send(8'd3, 2'd1, 2'd0, 16'h0033, 2'd0, 1'b0, w);
        send(8'd4, 2'd1, 2'd1, 16'h0044, 2'd3, 1'b0, w);
        send(8'd4, 2'd1, 2'd0, 16'h0044, 2'd3, 1'b0, w);
        chk_out("il4", 1'b1, 2'd1, 16'h0044, 2'd3, 1'b0, 3'b000);
        send(8'd3, 2'd1, 2'd1, 16'h0033, 2'd0, 1'b0, w);
        chk_out("il3", 1'b1, 2'd1, 16'h0033, 2'd0, 1'b0, 3'b000);

        for (int i = 0; i < 8; i++) begin
            send(8'(10 + i), 2'd1, 2'd0, 16'(16'h0100 + i), 2'(i), 1'b0, w);
        end
        in_tag = 8'd18; in_len = 2'd1; in_cl_num = 2'd0;
        in_mdata = 16'h0118; in_vc = 2'd2; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full.block", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(8'd10, 2'd1, 2'd1, 16'h0100, 2'd0, 1'b0, w);
        chk_out("full.free", 1'b1, 2'd1, 16'h0100, 2'd0, 1'b0, 3'b000);
        send(8'd18, 2'd1, 2'd0, 16'h0118, 2'd2, 1'b0, w);
        chk("full.accept9", 32'(w), 32'd0);

        out_ready = 1'b0;
        send(8'd11, 2'd1, 2'd1, 16'h0101, 2'd1, 1'b0, w);
        in_tag = 8'd12; in_len = 2'd1; in_cl_num = 2'd1;
        in_mdata = 16'h0102; in_vc = 2'd2; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall.valid", 32'(out_valid), 32'd1);
            chk("stall.mdata", 32'(out_mdata), 32'h0101);
            chk("stall.format", 32'(out_format), 32'd1);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(8'd12, 2'd1, 2'd1, 16'h0102, 2'd2, 1'b0, w);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        chk_idle("rst.drop", 3'b000);
        send(8'd13, 2'd1, 2'd1, 16'h00D1, 2'd1, 1'b0, w);
        chk_idle("rst.realloc", 3'b000);
        send(8'd13, 2'd1, 2'd0, 16'h00D0, 2'd3, 1'b0, w);
        chk_out("rst.fresh", 1'b1, 2'd1, 16'h00D1, 2'd1, 1'b0, 3'b000);

        send(8'd7, 2'd1, 2'd1, 16'h0077, 2'd0, 1'b0, w);
        chk_idle("dup.first", 3'b000);
        send(8'd7, 2'd1, 2'd1, 16'h0077, 2'd0, 1'b0, w);
        chk_idle("dup", 3'b001);
        send(8'd21, 2'd1, 2'd3, 16'h0021, 2'd0, 1'b0, w);
        chk_idle("cl_gt_len", 3'b011);
        send(8'd20, 2'd2, 2'd0, 16'h0020, 2'd0, 1'b0, w);
        chk_idle("len2", 3'b011);
        send(8'd0, 2'd0, 2'd0, 16'h00FE, 2'd2, 1'b1, w);
        chk_out("fence", 1'b0, 2'd0, 16'h00FE, 2'd2, 1'b1, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        chk_idle("err.sticky", 3'b111);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_idle("err.clear", 3'b000);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wrresp_packer.md
Name: wrresp_packer

Overview:
- Sits directly downstream of the out-of-order write/fence channel in the ASE CCI-P emulation path.
- Consumes per-cache-line write responses, which may arrive out of order and interleaved across requests.
- Emits one response per request:
  - single-CL requests pass through unpacked;
  - multi-CL requests (2 or 4 CL) are coalesced into one packed response (format=1) once all lines have arrived;
  - write-fence responses pass through, with an ordering check.

Parameters:
- DEPTH, 8: tracking-table entries (outstanding multi-CL requests).
- TAG_W, 8: width of the per-request unique tag assigned upstream.
- MDATA_W, 16: mdata width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  response line valid
- in_ready  out  1  block accepts line (transfer = in_valid & in_ready)
- in_tag  in  TAG_W  request tag; unique among outstanding requests
- in_vc  in  2  virtual channel
- in_len  in  2  request length: 0=1CL, 1=2CL, 3=4CL, 2 illegal
- in_cl_num  in  2  line index within request
- in_mdata  in  MDATA_W  request mdata
- in_is_fence  in  1  line is a WRFENCE response
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response
- out_vc  out  2  VC of response
- out_format  out  1  1 = packed multi-CL response
- out_cl_num  out  2  packed: in_len of request; unpacked: in_cl_num
- out_mdata  out  MDATA_W  mdata
- out_is_fence  out  1  fence response
- err  out  3  sticky errors: [0] duplicate line, [1] illegal len / cl_num>len, [2] fence with table non-empty

Behaviour:
- Reset (rst=0 at a clk edge): all table entries invalid, all masks cleared, out_valid=0, all out_* fields 0, err=0, in_ready=0 during reset.
- Output stage is a single register.
  - Load when out_valid=0 or out_ready=1.
  - Holds stable while out_valid & ~out_ready.
- Latency: the accepted line that completes a response produces out_valid on the next cycle. Each accepted line produces at most one response.
- in_ready = (~out_valid | out_ready) & ~(new multi-CL tag & table full).
  - A new multi-CL tag is in_len!=0, not a fence, and no valid entry matches in_tag.
- Per accepted line, the first matching case applies:
  1. Fence: emit out_is_fence=1, format=0, cl_num=0, with its vc and mdata. If any table entry is valid, set err[2]; the fence is still emitted.
  2. in_len==2 or in_cl_num>in_len: drop, set err[1], no output.
  3. in_len==0: emit unpacked, format=0, cl_num=in_cl_num.
  4. Multi-CL, tag hit:
     - if the mask bit is already set: drop, set err[0];
     - else set the bit; if the mask is now complete (2 or 4 bits) emit packed (format=1, cl_num=in_len, vc/mdata from entry) and free the entry in the same cycle.
  5. Multi-CL, tag miss: allocate the lowest free entry and store tag, len, vc, mdata, mask=1<<cl_num. No output. Completion occurs only on a later line.
- Entries store vc and mdata from the first line. Later lines' vc/mdata are ignored.
- Freeing and allocation in the same cycle cannot collide, because only one line is accepted per cycle.
- Table-full backpressure applies only to new multi-CL tags. Lines of existing tags, singles and fences are still throttled by the output stage.
- Reset asserted mid-operation discards all partial entries and any pending output. No response is emitted for them.

Optional Feature:
- Macro: ASE_WRRESP_STATS_EN.
- Defined:
  - adds outputs cnt_single, cnt_packed, cnt_fence, 32 bits each;
  - each increments when a response of that kind is loaded into the output stage;
  - counters saturate at all-ones and reset to 0.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package ase_pkg:
  - typedef wrresp_len_e (1CL/2CL/4CL);
  - struct wrresp_entry_t (valid, tag, len, vc, mdata, mask[3:0]);
  - function len_to_mask (returns 4'b0001 / 4'b0011 / 4'b1111).
- One sub-module: wrresp_track_table. Holds the CAM lookup on tag, lowest-free allocate, mask update/complete detect, and free.

Test Plan:
- Single line tag=1 len=0 cl=0 mdata=0x10 vc=1 -> next cycle out_valid, format=0, cl_num=0, mdata=0x10, vc=1.
- 4CL request tag=5 mdata=0xAB: lines cl=2,0,3,1 on consecutive cycles -> no output for the first three; one packed response one cycle after cl=1 (format=1, cl_num=3, mdata=0xAB); table empty afterwards.
- Interleaved 2CL tags 3 and 4 (order: 3/cl0, 4/cl1, 4/cl0, 3/cl1) -> packed tag 4 first, then tag 3; both cl_num=1.
- Fill table with 8 partial 2CL requests, present a 9th new tag -> in_ready=0 until one completes, then the 9th line is accepted. Repeat with out_ready=0 held 5 cycles -> out_* stable and in_ready=0 throughout.
- Error cases:
  - duplicate tag=7 cl=1 -> err[0]=1, no output;
  - len=2 -> err[1]=1;
  - fence while one entry is pending -> fence emitted, err[2]=1;
  - err stays set until reset.
- Reset pulse with two partial entries pending -> no responses; a subsequent completion line for an old tag allocates a fresh entry (no output).
